// File: rtl/cpu_qsys_oci_trace_monitor.sv
// Captures OCI debug-core trace frames into a FIFO, streams them out as valid/ready,
// and sequences the end-of-test drain. Optional running checksum: OCI_TRACE_CHECKSUM_EN.
module cpu_qsys_oci_trace_monitor #(
  parameter int FRAME_W = 30,
  parameter int COUNT_W = 4,
  parameter int DEPTH   = 16,
  parameter int LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [FRAME_W-1:0]         dct_buffer,
  input  logic [COUNT_W-1:0]         dct_count,
  input  logic                       dct_valid,
  input  logic                       test_ending,
  output logic [FRAME_W+COUNT_W-1:0] trace_data,
  output logic                       trace_valid,
  input  logic                       trace_ready,
  output logic [LVL_W-1:0]           fill_level,
  output logic                       overflow,
  output logic [15:0]                drop_count,
  output logic                       test_has_ended,
  output logic [31:0]                checksum
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int DATA_W = FRAME_W + COUNT_W;

  typedef enum logic [1:0] {CAPTURE, DRAIN, DONE} state_t;

  state_t              state_reg;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg;
  logic [PTR_W-1:0]    rd_ptr_reg;
  logic [LVL_W-1:0]    fill_reg;
  logic [LVL_W-1:0]    fill_next;
  logic                overflow_reg;
  logic [15:0]         drop_reg;
  logic                ended_reg;

  logic                push_req;
  logic                full;
  logic                push;
  logic                pop;
  logic                drop;
  logic [DATA_W-1:0]   push_word;

  assign push_word = {dct_count, dct_buffer};
  assign push_req  = (state_reg == CAPTURE) && dct_valid && (dct_count != '0);
  assign full      = (fill_reg == LVL_W'(DEPTH));
  assign trace_valid = (fill_reg != '0);
  assign pop       = trace_valid && trace_ready;
  // A full FIFO still accepts a frame when the head leaves in the same cycle.
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;

  always_comb begin
    fill_next = fill_reg;
    if (push && !pop)
      fill_next = fill_reg + LVL_W'(1);
    else if (pop && !push)
      fill_next = fill_reg - LVL_W'(1);
  end

  // Storage is deliberately not reset; the empty-head mux hides stale contents.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= push_word;
  end

  assign trace_data = trace_valid ? mem[rd_ptr_reg] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= CAPTURE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fill_reg     <= '0;
      overflow_reg <= 1'b0;
      drop_reg     <= '0;
      ended_reg    <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      fill_reg <= fill_next;
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_reg != 16'hFFFF)
          drop_reg <= drop_reg + 16'd1;
      end
      case (state_reg)
        CAPTURE: if (test_ending) state_reg <= DRAIN;
        DRAIN: begin
          // Post-pop fill decides completion, so an empty FIFO finishes one cycle after entry.
          if (fill_next == '0) begin
            state_reg <= DONE;
            ended_reg <= 1'b1;
          end
        end
        default: state_reg <= DONE;
      endcase
    end
  end

  assign fill_level     = fill_reg;
  assign overflow       = overflow_reg;
  assign drop_count     = drop_reg;
  assign test_has_ended = ended_reg;

`ifdef OCI_TRACE_CHECKSUM_EN
  localparam int EXT_W = (DATA_W > 32) ? DATA_W : 32;
  logic [EXT_W-1:0] push_ext;
  logic [31:0]      checksum_reg;

  // Frames wider than 32 bits contribute only their low word.
  assign push_ext = EXT_W'(push_word);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      checksum_reg <= '0;
    else if (push)
      checksum_reg <= {checksum_reg[30:0], checksum_reg[31]} ^ push_ext[31:0];
  end

  assign checksum = checksum_reg;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_cpu_qsys_oci_trace_monitor.sv
// Directed scoreboard bench for cpu_qsys_oci_trace_monitor at DEPTH=4.
module tb_cpu_qsys_oci_trace_monitor;

  localparam int FRAME_W = 30;
  localparam int COUNT_W = 4;
  localparam int DEPTH   = 4;
  localparam int LVL_W   = 3;
  localparam int DATA_W  = FRAME_W + COUNT_W;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [FRAME_W-1:0] dct_buffer;
  logic [COUNT_W-1:0] dct_count;
  logic               dct_valid;
  logic               test_ending;
  logic [DATA_W-1:0]  trace_data;
  logic               trace_valid;
  logic               trace_ready;
  logic [LVL_W-1:0]   fill_level;
  logic               overflow;
  logic [15:0]        drop_count;
  logic               test_has_ended;
  logic [31:0]        checksum;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [31:0]       exp_cs;

  cpu_qsys_oci_trace_monitor #(
    .FRAME_W(FRAME_W), .COUNT_W(COUNT_W), .DEPTH(DEPTH), .LVL_W(LVL_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .dct_valid(dct_valid), .test_ending(test_ending), .trace_data(trace_data),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .fill_level(fill_level),
    .overflow(overflow), .drop_count(drop_count), .test_has_ended(test_has_ended),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  // Monitor: each pop presented mid-cycle is compared against the oldest expected frame.
  always @(negedge clk) begin
    if (reset_n && trace_valid && trace_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %h, required no pop (queue empty)", trace_data);
      end else begin
        logic [DATA_W-1:0] e;
        e = exp_q.pop_front();
        if (trace_data !== e) begin
          errors++;
          $display("FAIL pop_data: got %h, required %h", trace_data, e);
        end else
          $display("pop ok: %h", trace_data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end else
      $display("check ok: %s = %h", name, act);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cs_next(input logic [31:0] cs, input logic [DATA_W-1:0] w);
`ifdef OCI_TRACE_CHECKSUM_EN
    logic [63:0] wx;
    wx = 64'(w);
    return {cs[30:0], cs[31]} ^ wx[31:0];
`else
    return cs ^ 32'(w & '0);
`endif
  endfunction

  // Drives one frame for a single cycle; accepted frames go to the scoreboard.
  task automatic send(input logic [COUNT_W-1:0] c, input logic [FRAME_W-1:0] b, input bit accepted);
    dct_valid  = 1'b1;
    dct_count  = c;
    dct_buffer = b;
    if (accepted) begin
      exp_q.push_back({c, b});
      exp_cs = cs_next(exp_cs, {c, b});
    end
    step();
    dct_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; dct_buffer = '0; dct_count = '0; dct_valid = 1'b0;
    test_ending = 1'b0; trace_ready = 1'b0; exp_cs = '0;
    #2;
    chk("rst_valid", 64'(trace_valid), 64'd0);
    chk("rst_fill", 64'(fill_level), 64'd0);
    chk("rst_data", 64'(trace_data), 64'd0);
    chk("rst_flags", {overflow, test_has_ended, drop_count, checksum}, 64'd0);
    step();
    reset_n = 1'b1;
    step();

    for (int i = 1; i <= 3; i++) send(4'h1, 30'(i), 1'b1);
    chk("fill_3", 64'(fill_level), 64'd3);
    chk("head_1", 64'(trace_data), {30'd0, 4'h1, 30'h1});
    chk("ovf_0", 64'(overflow), 64'd0);

    send(4'h1, 30'h4, 1'b1);
    send(4'h1, 30'h5, 1'b0);
    send(4'h1, 30'h6, 1'b0);
    chk("fill_full", 64'(fill_level), 64'd4);
    chk("drops_2", 64'(drop_count), 64'd2);
    chk("ovf_1", 64'(overflow), 64'd1);

    // Full plus simultaneous pop: frame 1 leaves, frame 7 wraps into slot 0.
    trace_ready = 1'b1;
    send(4'h2, 30'h7, 1'b1);
    trace_ready = 1'b0;
    chk("fill_keep4", 64'(fill_level), 64'd4);
    chk("drops_keep", 64'(drop_count), 64'd2);
    chk("head_2", 64'(trace_data), {30'd0, 4'h1, 30'h2});

    trace_ready = 1'b1;
    step(); step();
    trace_ready = 1'b0;
    chk("fill_2", 64'(fill_level), 64'd2);

    send(4'h0, 30'h3FF, 1'b0);
    chk("zero_cnt_fill", 64'(fill_level), 64'd2);
    chk("zero_cnt_drop", 64'(drop_count), 64'd2);

    test_ending = 1'b1;
    send(4'h3, 30'h8, 1'b1);
    test_ending = 1'b0;
    chk("end_fill_3", 64'(fill_level), 64'd3);
    dct_valid = 1'b1; dct_count = 4'h1; dct_buffer = 30'h9;
    trace_ready = 1'b1;
    step();
    chk("drain_fill_2", 64'(fill_level), 64'd2);
    chk("drain_not_ended", 64'(test_has_ended), 64'd0);
    step();
    chk("drain_fill_1", 64'(fill_level), 64'd1);
    step();
    chk("drain_fill_0", 64'(fill_level), 64'd0);
    chk("ended_1", 64'(test_has_ended), 64'd1);
    chk("drain_no_drop", 64'(drop_count), 64'd2);
    step(); step();
    dct_valid = 1'b0; trace_ready = 1'b0;
    chk("done_idle_fill", 64'(fill_level), 64'd0);
    chk("done_idle_valid", 64'(trace_valid), 64'd0);
    chk("done_ended", 64'(test_has_ended), 64'd1);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    exp_cs = '0;
    step();
    send(4'h1, 30'h5, 1'b1);
    chk("cs_first", 64'(checksum), 64'(exp_cs));
    send(4'h2, 30'h3, 1'b1);
    chk("cs_second", 64'(checksum), 64'(exp_cs));
    chk("cs_fill", 64'(fill_level), 64'd2);

    // Asynchronous reset mid-cycle, away from any clock edge.
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_valid", 64'(trace_valid), 64'd0);
    chk("arst_fill", 64'(fill_level), 64'd0);
    chk("arst_data", 64'(trace_data), 64'd0);
    chk("arst_flags", {overflow, test_has_ended, drop_count, checksum}, 64'd0);
    step();
    reset_n = 1'b1;
    step();

    test_ending = 1'b1;
    step();
    test_ending = 1'b0;
    chk("empty_drain_not_ended", 64'(test_has_ended), 64'd0);
    step();
    chk("empty_drain_ended", 64'(test_has_ended), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
